// File: rtl/jtdd_colmix.sv
// rtl/jtdd_colmix.sv - layer priority, palette lookup and blanking for the final video stage
// Optional layer masking is enabled with `define JTDD_COLMIX_LAYERMASK_EN.
module jtdd_colmix #(
    parameter int BLANK_DLY  = 3,
    parameter     SIMFILE_RG = "pal_rg.bin",
    parameter     SIMFILE_B  = "pal_b.bin"
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pxl_cen,
    input  logic       cen_Q,
    input  logic [9:0] cpu_AB,
    input  logic       pal_cs,
    input  logic       cpu_wrn,
    input  logic [7:0] cpu_dout,
    output logic [7:0] pal_dout,
    input  logic [6:0] char_pxl,
    input  logic [7:0] obj_pxl,
    input  logic [6:0] scr_pxl,
    input  logic [2:0] gfx_en,
    input  logic       LHBL,
    input  logic       LVBL,
    output logic       LHBL_dly,
    output logic       LVBL_dly,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue
);

    logic [7:0] rg_mem [0:511];
    logic [7:0] b_mem  [0:511];
    logic [7:0] rg_q0, b_q0, rg_q1, b_q1;
    logic       q2, we;

    logic [8:0] idx_nx, idx_s1;
    logic       kill_nx, kill_s1, kill_s2;
    logic       char_on, obj_on, scr_kill;

    logic [BLANK_DLY-1:0] h_sr, v_sr, h_nx, v_nx;

    logic unused_bits;
    assign unused_bits = ^{obj_pxl[7], gfx_en};

    // The CPU strobe lands one clk after its bus phase.
    always_ff @(posedge clk) begin
        if (rst) q2 <= 1'b0;
        else     q2 <= cen_Q;
    end

    assign we = q2 & pal_cs & ~cpu_wrn;

    // Port 0 serves the CPU, port 1 the display; a same-clk write leaves port 1 with the old word.
    always_ff @(posedge clk) begin
        if (we && !cpu_AB[9]) rg_mem[cpu_AB[8:0]] <= cpu_dout;
        if (we &&  cpu_AB[9]) b_mem[cpu_AB[8:0]]  <= cpu_dout;
        rg_q0 <= rg_mem[cpu_AB[8:0]];
        b_q0  <= b_mem[cpu_AB[8:0]];
        if (pxl_cen) begin
            rg_q1 <= rg_mem[idx_s1];
            b_q1  <= b_mem[idx_s1];
        end
    end

    assign pal_dout = cpu_AB[9] ? b_q0 : rg_q0;

    always_comb begin
        char_on  = char_pxl[3:0] != 4'd0;
        obj_on   = obj_pxl[3:0] != 4'd0;
        scr_kill = 1'b0;
`ifdef JTDD_COLMIX_LAYERMASK_EN
        char_on  = char_on & gfx_en[0];
        obj_on   = obj_on & gfx_en[2];
        scr_kill = ~gfx_en[1];
`endif
        if (char_on)     idx_nx = {2'b00, char_pxl};
        else if (obj_on) idx_nx = {2'b01, obj_pxl[6:0]};
        else             idx_nx = {2'b10, scr_pxl};
        kill_nx = ~char_on & ~obj_on & scr_kill;
    end

    always_comb begin
        h_nx[0] = LHBL;
        v_nx[0] = LVBL;
        for (int i = 1; i < BLANK_DLY; i++) begin
            h_nx[i] = h_sr[i-1];
            v_nx[i] = v_sr[i-1];
        end
    end

    assign LHBL_dly = h_sr[BLANK_DLY-1];
    assign LVBL_dly = v_sr[BLANK_DLY-1];

    // Blanking for S3 uses the value entering the last delay stage so RGB and *_dly stay aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_s1  <= '0;
            kill_s1 <= 1'b0;
            kill_s2 <= 1'b0;
            h_sr    <= '0;
            v_sr    <= '0;
            red     <= 4'd0;
            green   <= 4'd0;
            blue    <= 4'd0;
        end else if (pxl_cen) begin
            idx_s1  <= idx_nx;
            kill_s1 <= kill_nx;
            kill_s2 <= kill_s1;
            h_sr    <= h_nx;
            v_sr    <= v_nx;
            if (h_nx[BLANK_DLY-1] && v_nx[BLANK_DLY-1] && !kill_s2) begin
                red   <= rg_q1[3:0];
                green <= rg_q1[7:4];
                blue  <= b_q1[3:0];
            end else begin
                red   <= 4'd0;
                green <= 4'd0;
                blue  <= 4'd0;
            end
        end
    end

endmodule

// File: tb/tb_jtdd_colmix.sv
// tb/tb_jtdd_colmix.sv - directed vector bench for jtdd_colmix
module tb_jtdd_colmix;

    logic       clk = 1'b0;
    logic       rst, pxl_cen, cen_Q, pal_cs, cpu_wrn, LHBL, LVBL;
    logic [9:0] cpu_AB;
    logic [7:0] cpu_dout, pal_dout, obj_pxl;
    logic [6:0] char_pxl, scr_pxl;
    logic [2:0] gfx_en;
    logic       LHBL_dly, LVBL_dly;
    logic [3:0] red, green, blue;

    int n_cmp = 0;
    int n_bad = 0;

    jtdd_colmix dut (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .cen_Q(cen_Q), .cpu_AB(cpu_AB),
        .pal_cs(pal_cs), .cpu_wrn(cpu_wrn), .cpu_dout(cpu_dout), .pal_dout(pal_dout),
        .char_pxl(char_pxl), .obj_pxl(obj_pxl), .scr_pxl(scr_pxl), .gfx_en(gfx_en),
        .LHBL(LHBL), .LVBL(LVBL), .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly),
        .red(red), .green(green), .blue(blue)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] ch;
        logic [7:0] ob;
        logic [6:0] sc;
        logic       lh;
        logic       lv;
        logic [11:0] rgb;
    } vec_t;

    vec_t vec [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cpu_wr(input logic [9:0] a, input logic [7:0] d);
        @(negedge clk);
        cpu_AB = a; cpu_dout = d; pal_cs = 1'b1; cpu_wrn = 1'b0; cen_Q = 1'b1;
        @(negedge clk);
        cen_Q = 1'b0;
        @(negedge clk);
        pal_cs = 1'b0; cpu_wrn = 1'b1;
    endtask

    task automatic drive(input logic [6:0] c, input logic [7:0] o, input logic [6:0] s,
                         input logic h, input logic v);
        char_pxl = c; obj_pxl = o; scr_pxl = s; LHBL = h; LVBL = v;
    endtask

    initial begin
        //          char   obj    scr   lh    lv    {r,g,b}
        vec[0] = '{7'h13, 8'h00, 7'h00, 1'b1, 1'b1, 12'h5A7};
        vec[1] = '{7'h10, 8'h25, 7'h31, 1'b1, 1'b1, 12'hC39};
        vec[2] = '{7'h11, 8'h25, 7'h31, 1'b1, 1'b1, 12'h21E};
        vec[3] = '{7'h10, 8'h20, 7'h30, 1'b1, 1'b1, 12'hB64};
        vec[4] = '{7'h13, 8'h00, 7'h00, 1'b0, 1'b1, 12'h000};
        vec[5] = '{7'h13, 8'h00, 7'h00, 1'b1, 1'b1, 12'h5A7};
        vec[6] = '{7'h00, 8'hA5, 7'h00, 1'b1, 1'b1, 12'hC39};
        vec[7] = '{7'h70, 8'h00, 7'h22, 1'b1, 1'b1, 12'hD51};
        vec[8] = '{7'h13, 8'h00, 7'h00, 1'b1, 1'b0, 12'h000};
        vec[9] = '{7'h11, 8'h00, 7'h00, 1'b1, 1'b1, 12'h21E};

        rst = 1'b1; pxl_cen = 1'b1; cen_Q = 1'b0; pal_cs = 1'b0; cpu_wrn = 1'b1;
        cpu_AB = '0; cpu_dout = '0; gfx_en = 3'b111;
        drive(7'h13, 8'h25, 7'h31, 1'b1, 1'b1);

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("reset_rgb", {red, green, blue}, 12'h000);
            check("reset_dly", {LHBL_dly, LVBL_dly}, 2'b00);
        end
        rst = 1'b0;

        cpu_wr(10'h013, 8'hA5); cpu_wr(10'h213, 8'h07);
        cpu_wr(10'h0A5, 8'h3C); cpu_wr(10'h2A5, 8'h09);
        cpu_wr(10'h011, 8'h12); cpu_wr(10'h211, 8'hFE);
        cpu_wr(10'h130, 8'h6B); cpu_wr(10'h330, 8'h04);
        cpu_wr(10'h122, 8'h5D); cpu_wr(10'h322, 8'h01);
        cpu_wr(10'h022, 8'h00); cpu_wr(10'h222, 8'h00);

        @(negedge clk); cpu_AB = 10'h013;
        @(negedge clk); check("pal_dout_rg013", pal_dout, 8'hA5);
        cpu_AB = 10'h211;
        @(negedge clk); check("pal_dout_b011", pal_dout, 8'hFE);
        cpu_AB = 10'h130;
        @(negedge clk); check("pal_dout_rg130", pal_dout, 8'h6B);

        // Streamed one vector per pixel; each result is due exactly 3 pixels later.
        for (int i = 0; i < 13; i++) begin
            if (i >= 3) begin
                check($sformatf("vec%0d_rgb", i - 3), {red, green, blue}, vec[i-3].rgb);
                check($sformatf("vec%0d_dly", i - 3), {LHBL_dly, LVBL_dly},
                      {vec[i-3].lh, vec[i-3].lv});
            end
            if (i < 10) drive(vec[i].ch, vec[i].ob, vec[i].sc, vec[i].lh, vec[i].lv);
            @(negedge clk);
        end

        pxl_cen = 1'b0;
        drive(7'h13, 8'h00, 7'h00, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("hold_rgb", {red, green, blue}, 12'h21E);
        check("hold_dly", LHBL_dly, 1'b1);
        pxl_cen = 1'b1; LHBL = 1'b1;
        repeat (3) @(negedge clk);
        check("resume_rgb", {red, green, blue}, 12'h5A7);

        // Write 0x022 on the same clk the display reads it.
        cpu_AB = 10'h022; cpu_dout = 8'hFF; pal_cs = 1'b1; cpu_wrn = 1'b0; cen_Q = 1'b1;
        char_pxl = 7'h22;
        @(negedge clk); cen_Q = 1'b0; char_pxl = 7'h13;
        @(negedge clk); pal_cs = 1'b0; cpu_wrn = 1'b1;
        @(negedge clk); check("collide_old", {red, green, blue}, 12'h000);
        char_pxl = 7'h22;
        repeat (3) @(negedge clk);
        check("collide_new", {red, green, blue}, 12'hFF0);

`ifdef JTDD_COLMIX_LAYERMASK_EN
        gfx_en = 3'b110;
        drive(7'h15, 8'h00, 7'h22, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        check("mask_char", {red, green, blue}, 12'hD51);
        gfx_en = 3'b000;
        repeat (3) @(negedge clk);
        check("mask_all", {red, green, blue}, 12'h000);
        gfx_en = 3'b111;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
